// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the UART byte path and the 16-bit clocked ALU.
// Assembles CC/DD commands, pulses the ALU, and returns the result low byte first.
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ALU_WIDTH  = 2 * DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER   = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_NOOPER = 8'hDD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  output logic [ALU_WIDTH-1:0]  A,
  output logic [ALU_WIDTH-1:0]  B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_BUSY
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_ISSUE, ALU_WAIT,
    TX_LO, TX_ACK_LO, TX_HI, TX_ACK_HI
  } state_t;

  state_t                 state, state_next;
  logic [ALU_WIDTH-1:0]   result, result_next;
  logic [ALU_WIDTH-1:0]   a_next, b_next;
  logic [3:0]             fun_next;
  logic [DATA_WIDTH-1:0]  tx_data_next;
  logic                   tx_vld_next;
  logic                   alu_en_next;
  logic                   gate_next;
  logic                   busy_next;
  logic [ALU_WIDTH-1:0]   rx_ext;

  assign rx_ext = {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, RX_P_DATA};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    a_next       = A;
    b_next       = B;
    fun_next     = ALU_FUN;
    result_next  = result;
    tx_data_next = TX_P_DATA;
    tx_vld_next  = 1'b0;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_OPER)        state_next = GET_A;
          else if (RX_P_DATA == CMD_NOOPER) state_next = GET_FUN;
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          a_next     = rx_ext;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          b_next     = rx_ext;
          state_next = GET_FUN;
        end
      end
      GET_FUN: begin
        if (RX_D_VLD) begin
          fun_next   = RX_P_DATA[3:0];
          state_next = ALU_ISSUE;
        end
      end
      ALU_ISSUE: state_next = ALU_WAIT;
      ALU_WAIT: begin
        // ALU_OUT was registered by the ALU on the edge that ended ALU_ISSUE
        result_next = ALU_OUT;
        state_next  = TX_LO;
      end
      TX_LO: begin
        if (!TX_BUSY) begin
          tx_vld_next  = 1'b1;
          tx_data_next = result[DATA_WIDTH-1:0];
          state_next   = TX_ACK_LO;
        end
      end
      TX_ACK_LO: if (TX_BUSY) state_next = TX_HI;
      TX_HI: begin
        if (!TX_BUSY) begin
          tx_vld_next  = 1'b1;
          tx_data_next = result[ALU_WIDTH-1:DATA_WIDTH];
          state_next   = TX_ACK_HI;
        end
      end
      TX_ACK_HI: if (TX_BUSY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Control outputs are registered, so they are decoded from the next state
    alu_en_next = (state_next == ALU_ISSUE);
    gate_next   = (state_next == ALU_ISSUE) || (state_next == ALU_WAIT);
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      A           <= '0;
      B           <= '0;
      ALU_FUN     <= '0;
      result      <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      CMD_BUSY    <= 1'b0;
    end else begin
      A           <= a_next;
      B           <= b_next;
      ALU_FUN     <= fun_next;
      result      <= result_next;
      ALU_EN      <= alu_en_next;
      CLK_GATE_EN <= gate_next;
      TX_P_DATA   <= tx_data_next;
      TX_D_VLD    <= tx_vld_next;
      CMD_BUSY    <= busy_next;
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed and random commands against a command-level
// reference model, with a stand-in clocked ALU and a UART transmitter model.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] ALU_OUT;
  logic [15:0] A, B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, CLK_GATE_EN, TX_D_VLD, TX_BUSY, CMD_BUSY;
  logic [7:0]  TX_P_DATA;

  always #5 CLK = ~CLK;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY), .CMD_BUSY(CMD_BUSY)
  );

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b != 0) ? a / b : 16'h0;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return ~(a & b);
      4'h7: return ~(a | b);
      4'h8: return a ^ b;
      4'h9: return ~(a ^ b);
      4'hA: return (a == b) ? 16'd1 : 16'd0;
      4'hB: return (a > b) ? 16'd2 : 16'd0;
      4'hC: return (a < b) ? 16'd3 : 16'd0;
      4'hD: return a >> 1;
      4'hE: return a << 1;
      default: return b >> 1;
    endcase
  endfunction

  // Stand-in ALU: registers its result only when enabled and clocked
  logic [15:0] alu_reg = 16'h0;
  always @(posedge CLK) if (ALU_EN && CLK_GATE_EN) alu_reg <= alu_ref(A, B, ALU_FUN);
  assign ALU_OUT = alu_reg;

  int          cyc = 0, strobe_cyc = 0, en_cyc = 0, en_count = 0, gate_count = 0, dbl_vld = 0;
  int          busy_cnt = 0;
  logic        prev_vld = 1'b0;
  logic [15:0] a_seen = 0, b_seen = 0;
  logic [3:0]  fun_seen = 0;
  logic [7:0]  tx_q[$];
  bit          busy_force = 1'b0, no_busy = 1'b0;

  assign TX_BUSY = busy_force || (busy_cnt != 0);

  always @(negedge CLK) begin
    cyc++;
    if (RX_D_VLD) strobe_cyc = cyc;
    if (ALU_EN) begin
      en_cyc = cyc; en_count++; a_seen = A; b_seen = B; fun_seen = ALU_FUN;
    end
    if (CLK_GATE_EN) gate_count++;
    if (TX_D_VLD) begin
      tx_q.push_back(TX_P_DATA);
      if (prev_vld) dbl_vld++;
      if (!no_busy) busy_cnt = $urandom_range(6, 2);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_vld = TX_D_VLD;
  end

  int          total = 0, bad = 0;
  logic [15:0] ref_a = 0, ref_b = 0;
  logic [7:0]  exp_lo, exp_hi;
  logic [3:0]  exp_fun;
  int          fun_cyc, en_base, gate_base, tx_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] da, input logic [7:0] db,
                          input logic [7:0] fun);
    logic [15:0] r;
    en_base = en_count; gate_base = gate_count; tx_base = tx_q.size();
    send_byte(op);
    if (op == 8'hCC) begin
      send_byte(da); send_byte(db);
      ref_a = {8'h00, da}; ref_b = {8'h00, db};
    end
    send_byte(fun);
    fun_cyc = strobe_cyc;
    exp_fun = fun[3:0];
    r = alu_ref(ref_a, ref_b, exp_fun);
    exp_lo = r[7:0]; exp_hi = r[15:8];
  endtask

  task automatic finish_cmd(input string tag);
    int n = 0;
    while (((tx_q.size() - tx_base) < 2 || CMD_BUSY) && n < 400) begin
      @(negedge CLK); n++;
    end
    check({tag, "_done"}, (n < 400), 1);
    check({tag, "_txcnt"}, tx_q.size() - tx_base, 2);
    if (tx_q.size() - tx_base >= 2) begin
      check({tag, "_lo"}, tx_q[tx_base], exp_lo);
      check({tag, "_hi"}, tx_q[tx_base+1], exp_hi);
    end
    check({tag, "_en_cnt"}, en_count - en_base, 1);
    check({tag, "_gate_cnt"}, gate_count - gate_base, 2);
    check({tag, "_en_lat"}, en_cyc - fun_cyc, 1);
    check({tag, "_a"}, a_seen, ref_a);
    check({tag, "_b"}, b_seen, ref_b);
    check({tag, "_fun"}, fun_seen, exp_fun);
    check({tag, "_txhold"}, TX_P_DATA, exp_hi);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_A"}, A, 0);
    check({tag, "_B"}, B, 0);
    check({tag, "_fun"}, ALU_FUN, 0);
    check({tag, "_en"}, ALU_EN, 0);
    check({tag, "_gate"}, CLK_GATE_EN, 0);
    check({tag, "_txd"}, TX_P_DATA, 0);
    check({tag, "_txv"}, TX_D_VLD, 0);
    check({tag, "_busy"}, CMD_BUSY, 0);
  endtask

  initial begin
    logic [7:0] g, op;
    int n;
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("rst");
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    send_cmd(8'hDD, 8'h00, 8'h00, 8'h06); finish_cmd("nooper_first");
    send_cmd(8'hCC, 8'h06, 8'h08, 8'h00); finish_cmd("add");
    send_cmd(8'hCC, 8'h0F, 8'h05, 8'h02); finish_cmd("mul");
    send_cmd(8'hDD, 8'h00, 8'h00, 8'h01); finish_cmd("nooper_sub");
    send_cmd(8'hCC, 8'h2C, 8'h60, 8'h06); finish_cmd("nand");
    send_cmd(8'hCC, 8'h2C, 8'h60, 8'hF6); finish_cmd("nand_hinib");
    send_byte(8'h55);
    send_cmd(8'hCC, 8'h58, 8'h00, 8'h0E); finish_cmd("shl");

    busy_force = 1'b1;
    send_cmd(8'hCC, 8'h12, 8'h34, 8'h08);
    repeat (20) @(posedge CLK);
    send_byte(8'h77);
    check("hold_novld", tx_q.size() - tx_base, 0);
    check("hold_busy", CMD_BUSY, 1);
    busy_force = 1'b0;
    finish_cmd("hold");
    send_cmd(8'hCC, 8'h77, 8'h09, 8'h01); finish_cmd("after_drop");

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < $urandom_range(2, 0); k++) begin
        g = 8'($urandom_range(255, 0));
        if (g == 8'hCC || g == 8'hDD) g = 8'h00;
        send_byte(g);
      end
      op = ($urandom_range(9, 0) < 7) ? 8'hCC : 8'hDD;
      send_cmd(op, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
               8'($urandom_range(255, 0)));
      finish_cmd($sformatf("rnd%0d", i));
    end

    no_busy = 1'b1;
    send_cmd(8'hCC, 8'h40, 8'h02, 8'h02);
    n = 0;
    while ((tx_q.size() - tx_base) < 1 && n < 200) begin
      @(negedge CLK); n++;
    end
    check("mid_lo_seen", (n < 200), 1);
    if (tx_q.size() > tx_base) check("mid_lo_byte", tx_q[tx_base], exp_lo);
    @(posedge CLK); #2;
    RST = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    no_busy = 1'b0;
    ref_a = 16'h0; ref_b = 16'h0;
    repeat (30) @(posedge CLK);
    #1 check("mid_no_hi", tx_q.size() - tx_base, 1);
    check("mid_idle", CMD_BUSY, 0);
    send_cmd(8'hDD, 8'h00, 8'h00, 8'h06); finish_cmd("post_rst");

    check("dbl_vld", dbl_vld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer that sits directly upstream of the 16-bit clocked ALU. It takes bytes from the UART receive path, assembles ALU commands (operands and function code), and drives the ALU operand and function inputs. It issues one enable pulse, gates the ALU clock on only around each operation, captures the ALU result, and returns the result to the UART transmitter as two bytes, low byte first. This is the controller that drives the ALU in the multi-clock system.

Parameters:
DATA_WIDTH, 8, width of the UART byte path.
ALU_WIDTH, 16, width of the ALU operands and result (2*DATA_WIDTH).
CMD_OPER, 8'hCC, opcode for a full command: operand A, operand B, then function code.
CMD_NOOPER, 8'hDD, opcode for a function-only command that reuses the stored operands.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  8  received byte
RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid
ALU_OUT  in  16  ALU result; registered inside the ALU on CLK
A  out  16  operand A to the ALU
B  out  16  operand B to the ALU
ALU_FUN  out  4  function code to the ALU
ALU_EN  out  1  one-cycle enable for the ALU operation
CLK_GATE_EN  out  1  enable for the ALU clock-gating cell
TX_P_DATA  out  8  byte to transmit
TX_D_VLD  out  1  one-cycle transmit request
TX_BUSY  in  1  transmitter is busy
CMD_BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; A=0, B=0, ALU_FUN=0, result register=0.
- Reset values of control outputs: ALU_EN=0, CLK_GATE_EN=0, TX_D_VLD=0, TX_P_DATA=0, CMD_BUSY=0.
- All outputs are registered.
- RX_P_DATA is zero-extended to 16 bits when it is loaded into A or B.
- The function code is taken from RX_P_DATA[3:0]; bits [7:4] are ignored.
- IDLE:
  - RX_D_VLD with CMD_OPER -> GET_A.
  - RX_D_VLD with CMD_NOOPER -> GET_FUN.
  - Any other byte is ignored; stay in IDLE.
- GET_A: the next RX_D_VLD loads A -> GET_B.
- GET_B: the next RX_D_VLD loads B -> GET_FUN.
- GET_FUN: the next RX_D_VLD loads ALU_FUN -> ALU_ISSUE.
- No timeout applies in the GET_* states.
- ALU_ISSUE (1 cycle): ALU_EN=1 and CLK_GATE_EN=1; A, B and ALU_FUN are stable -> ALU_WAIT.
- ALU_WAIT (1 cycle): CLK_GATE_EN=1; ALU_OUT is captured into the result register at the end of this cycle -> TX_LO.
- CLK_GATE_EN is low in every state other than ALU_ISSUE and ALU_WAIT.
- Operand-issue latency: the FUN byte strobe to ALU_EN is 1 cycle.
- TX_LO:
  - Wait for TX_BUSY=0.
  - Then pulse TX_D_VLD for one cycle with TX_P_DATA=result[7:0] -> TX_ACK_LO.
- TX_ACK_LO: wait for TX_BUSY=1 -> TX_HI.
- TX_HI:
  - Wait for TX_BUSY=0.
  - Then pulse TX_D_VLD with TX_P_DATA=result[15:8] -> TX_ACK_HI.
- TX_ACK_HI: wait for TX_BUSY=1 -> IDLE.
- TX_D_VLD is never high for more than one consecutive cycle.
- TX_P_DATA holds its value until the next send.
- RX_D_VLD in any state from ALU_ISSUE through TX_ACK_HI: the byte is dropped with no state change, and no byte is queued.
- CMD_NOOPER issued before any CMD_OPER uses A=B=0.
- An opcode byte that arrives in a GET_* state is treated as data, not as an opcode.
- RST asserted mid-command or mid-transmit:
  - Immediate return to reset values.
  - Any partially sent result is abandoned.
  - No TX_D_VLD is generated after reset is released until a new command completes.

Test Plan:
- CC,06,08,00 -> ALU_EN pulse 1 cycle after the FUN strobe, A=6, B=8; TX bytes 0x0E then 0x00.
- CC,0F,05,02 then DD,01 -> first result bytes 0x4B,0x00 (75); second result uses stored A=15, B=5, bytes 0x0A,0x00.
- CC,2C,60,06 (NAND 44,96) -> bytes 0xDF then 0xFF. FUN byte 0xF6 produces the same result (upper nibble ignored).
- Byte 0x55 in IDLE, then CC,58,00,0E -> 0x55 ignored; shift-left result 0x00B0, bytes 0xB0,0x00. CLK_GATE_EN is high for exactly 2 cycles per command.
- Hold TX_BUSY=1 for 20 cycles at TX_LO and inject an RX byte 0x77 meanwhile -> no TX_D_VLD until TX_BUSY falls. 0x77 is dropped; the next command decodes normally.
- Assert RST during TX_ACK_LO -> all outputs return to reset values at once; no high byte is sent; CMD_BUSY=0.
